wide_add_sequencer: RTL

- Multi-precision add controller wrapped around the team's registered 16-bit adder.
- Accepts wide operands over a valid/ready handshake and slices them into SLICE_W chunks, least significant first.
- Drives each slice into the adder with the correct carry, waits out the adder's pipeline latency, and collects each slice sum and carry.
- Presents the reassembled wide sum and final carry over a valid/ready output handshake.

---
 rtl/wide_add_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-precision add controller that feeds a registered SLICE_W-bit adder
// one slice at a time (LSB first), then presents the reassembled wide sum.
module wide_add_sequencer #(
  parameter int SLICE_W       = 16,
  parameter int NUM_SLICES    = 4,
  parameter int ADDER_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] a_wide,
  input  logic [SLICE_W*NUM_SLICES-1:0] b_wide,
  input  logic                          c_in,
  output logic [SLICE_W-1:0]            add_a,
  output logic [SLICE_W-1:0]            add_b,
  output logic                          add_cin,
  input  logic [SLICE_W-1:0]            add_sum,
  input  logic                          add_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] sum_wide,
  output logic                          c_out
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SUM = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q;
  logic [W-1:0]       opA_q;
  logic [W-1:0]       opB_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic [SLICE_W-1:0] addA_q;
  logic [SLICE_W-1:0] addB_q;
  logic               addCin_q;
  logic               inReady_q;
  logic               outValid_q;

  logic [IDX_W-1:0]   nextIdx_d;
  logic [SLICE_W-1:0] nextA_d;
  logic [SLICE_W-1:0] nextB_d;

  // Operand slices for the slice after the current one, loaded into the adder
  // port registers at the capture edge so the next ISSUE cycle presents them.
  always_comb begin
    nextIdx_d = idx_q + IDX_W'(1);
    nextA_d   = opA_q[nextIdx_d*SLICE_W +: SLICE_W];
    nextB_d   = opB_q[nextIdx_d*SLICE_W +: SLICE_W];
  end

  // Sequencer FSM: every output is a register so the adder sees clean,
  // glitch-free operands that stay put for the whole adder pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      addA_q     <= '0;
      addB_q     <= '0;
      addCin_q   <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q     <= a_wide;
            opB_q     <= b_wide;
            carry_q   <= c_in;
            idx_q     <= '0;
            addA_q    <= a_wide[SLICE_W-1:0];
            addB_q    <= b_wide[SLICE_W-1:0];
            addCin_q  <= c_in;
            inReady_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(ADDER_LATENCY - 1);
          state_q <= WAIT_SUM;
        end
        WAIT_SUM: begin
          if (cnt_q == '0) begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= add_sum;
            carry_q                         <= add_cout;
            if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
              cout_q     <= add_cout;
              addA_q     <= '0;
              addB_q     <= '0;
              addCin_q   <= 1'b0;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              idx_q    <= nextIdx_d;
              addA_q   <= nextA_d;
              addB_q   <= nextB_d;
              addCin_q <= add_cout;
              state_q  <= ISSUE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign sum_wide  = sum_q;
  assign c_out     = cout_q;
  assign add_a     = addA_q;
  assign add_b     = addB_q;
  assign add_cin   = addCin_q;

endmodule
